// File: rtl/clk_divider_prog.sv
// ============================================================================
//  Module   : clk_divider_prog
//  Brief    : Multi-channel programmable clock-enable / tick generator with
//             glitch-free reprogramming at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_divider_prog #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 500,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_load,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] cfg_pending
);

    localparam logic [DIV_W-1:0] c_default_div  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_default_high = DIV_W'(DEFAULT_DIV / 2);
    localparam logic [DIV_W-1:0] c_min_div      = DIV_W'(2);
    localparam logic [DIV_W-1:0] c_one          = DIV_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A divide ratio below 2 cannot produce a distinct tick cycle.
    logic [DIV_W-1:0] w_cfg_div_clamped;
    assign w_cfg_div_clamped = (cfg_div < c_min_div) ? c_min_div : cfg_div;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           r_state;
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_high;
        logic [DIV_W-1:0] r_sh_div;
        logic [DIV_W-1:0] r_sh_high;
        logic             r_pending;
        logic             r_clk_out;
        logic             r_tick;

        state_t           w_nxt_state;
        logic [DIV_W-1:0] w_nxt_cnt;
        logic [DIV_W-1:0] w_nxt_div;
        logic [DIV_W-1:0] w_nxt_high;
        logic [DIV_W-1:0] w_nxt_sh_div;
        logic [DIV_W-1:0] w_nxt_sh_high;
        logic             w_nxt_pending;
        logic             w_hit;
        logic             w_wrap;
        logic             w_nxt_run;

        assign w_hit  = cfg_load && (cfg_sel == SEL_W'(i));
        assign w_wrap = (r_state == ST_RUN) && (r_cnt == (r_div - c_one));

        // IDLE edges and wrap edges are both period boundaries: the only
        // points where active settings may change.
        always_comb begin
            w_nxt_state   = r_state;
            w_nxt_cnt     = r_cnt;
            w_nxt_div     = r_div;
            w_nxt_high    = r_high;
            w_nxt_sh_div  = r_sh_div;
            w_nxt_sh_high = r_sh_high;
            w_nxt_pending = r_pending;
            if ((r_state == ST_IDLE) || w_wrap) begin
                w_nxt_cnt   = '0;
                w_nxt_state = en[i] ? ST_RUN : ST_IDLE;
                if (w_wrap && w_hit) begin
                    w_nxt_div     = w_cfg_div_clamped;
                    w_nxt_high    = cfg_high;
                    w_nxt_sh_div  = w_cfg_div_clamped;
                    w_nxt_sh_high = cfg_high;
                    w_nxt_pending = 1'b0;
                end else begin
                    if (r_pending) begin
                        w_nxt_div     = r_sh_div;
                        w_nxt_high    = r_sh_high;
                        w_nxt_pending = 1'b0;
                    end
                    if (w_hit) begin
                        w_nxt_sh_div  = w_cfg_div_clamped;
                        w_nxt_sh_high = cfg_high;
                        w_nxt_pending = 1'b1;
                    end
                end
            end else begin
                w_nxt_cnt = r_cnt + c_one;
                if (w_hit) begin
                    w_nxt_sh_div  = w_cfg_div_clamped;
                    w_nxt_sh_high = cfg_high;
                    w_nxt_pending = 1'b1;
                end
            end
        end

        assign w_nxt_run = (w_nxt_state == ST_RUN);

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_div     <= c_default_div;
                r_high    <= c_default_high;
                r_sh_div  <= c_default_div;
                r_sh_high <= c_default_high;
                r_pending <= 1'b0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_state   <= w_nxt_state;
                r_cnt     <= w_nxt_cnt;
                r_div     <= w_nxt_div;
                r_high    <= w_nxt_high;
                r_sh_div  <= w_nxt_sh_div;
                r_sh_high <= w_nxt_sh_high;
                r_pending <= w_nxt_pending;
                // Outputs come from next-state so they line up with r_cnt.
                r_clk_out <= w_nxt_run && (w_nxt_cnt < w_nxt_high);
                r_tick    <= w_nxt_run && (w_nxt_cnt == (w_nxt_div - c_one));
            end
        end

        assign clk_out[i]     = r_clk_out;
        assign tick[i]        = r_tick;
        assign busy[i]        = (r_state == ST_RUN);
        assign cfg_pending[i] = r_pending;
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed boundary sequences, a
// duty/divide vector table and randomized traffic against a period model.
`default_nettype none

module tb_clk_divider_prog;

    localparam int CH = 3;
    localparam int DW = 16;
    localparam int SW = 2;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          cfg_load;
    logic [SW-1:0] cfg_sel;
    logic [DW-1:0] cfg_div;
    logic [DW-1:0] cfg_high;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;
    logic [CH-1:0] cfg_pending;

    clk_divider_prog #(
        .CHANNELS   (CH),
        .DIV_W      (DW),
        .DEFAULT_DIV(500)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_sel    (cfg_sel),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .cfg_pending(cfg_pending)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within the current period plus the settings
    // that govern this period and the one queued for the next.
    bit m_run [CH];
    int m_pos [CH];
    int m_div [CH];
    int m_high[CH];
    int m_qdiv[CH];
    int m_qhigh[CH];
    bit m_pend[CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c]   = 0;
            m_pos[c]   = 0;
            m_div[c]   = 500;
            m_high[c]  = 250;
            m_qdiv[c]  = 500;
            m_qhigh[c] = 250;
            m_pend[c]  = 0;
        end
    endfunction

    function automatic void model_edge();
        int  req_div;
        bit  hit;
        bit  period_end;
        req_div = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        for (int c = 0; c < CH; c++) begin
            hit        = cfg_load && (int'(cfg_sel) == c);
            period_end = !m_run[c] || (m_pos[c] == m_div[c] - 1);
            if (!period_end) begin
                m_pos[c] = m_pos[c] + 1;
            end else begin
                if (m_run[c] && hit) begin
                    m_div[c]  = req_div;
                    m_high[c] = int'(cfg_high);
                    hit       = 0;
                end else if (m_pend[c]) begin
                    m_div[c]  = m_qdiv[c];
                    m_high[c] = m_qhigh[c];
                end
                m_pend[c] = 0;
                m_run[c]  = en[c];
                m_pos[c]  = 0;
            end
            if (hit) begin
                m_qdiv[c]  = req_div;
                m_qhigh[c] = int'(cfg_high);
                m_pend[c]  = 1;
            end
        end
    endfunction

    task automatic step();
        logic [CH-1:0] e_clk, e_tick, e_busy, e_pend;
        @(posedge clk_in);
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            e_clk[c]  = m_run[c] && (m_pos[c] < m_high[c]);
            e_tick[c] = m_run[c] && (m_pos[c] == m_div[c] - 1);
            e_busy[c] = m_run[c];
            e_pend[c] = m_pend[c];
        end
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    endtask

    task automatic load(input int c, input int d, input int h);
        cfg_load = 1'b1;
        cfg_sel  = SW'(c);
        cfg_div  = DW'(d);
        cfg_high = DW'(h);
        step();
        cfg_load = 1'b0;
    endtask

    task automatic wait_pos(input int c, input int p);
        int k = 0;
        while (!(m_run[c] && m_pos[c] == p) && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) timeout("wait_pos");
    endtask

    task automatic drain(input int c);
        int k = 0;
        en[c] = 1'b0;
        while (m_run[c] && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) timeout("drain");
    endtask

    task automatic measure(input int c, input int n, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int k = 0; k < n; k++) begin
            step();
            highs += int'(clk_out[c]);
            ticks += int'(tick[c]);
        end
    endtask

    typedef struct {
        int div_in;
        int high_in;
        int eff_div;
        int exp_high;
        int exp_ticks;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, t, k;

        // Four whole periods per entry: high cycles = 4*min(high,div).
        vecs[0] = '{1, 1, 2, 4, 4};
        vecs[1] = '{2, 0, 2, 0, 4};
        vecs[2] = '{4, 7, 4, 16, 4};
        vecs[3] = '{5, 2, 5, 8, 4};
        vecs[4] = '{20, 10, 20, 40, 4};
        vecs[5] = '{0, 0, 2, 0, 4};
        vecs[6] = '{3, 3, 3, 12, 4};

        reset    = 1'b1;
        en       = '0;
        cfg_load = 1'b0;
        cfg_sel  = '0;
        cfg_div  = '0;
        cfg_high = '0;
        model_reset();
        #1;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(cfg_pending), 0);
        #21 reset = 1'b0;

        // Default 500/250 on channel 0.
        en[0] = 1'b1;
        measure(0, 500, h, t);
        chk("default_high", h, 250);
        chk("default_ticks", t, 1);

        // Mid-period reload applies only at the wrap.
        wait_pos(0, 100);
        load(0, 5, 2);
        chk("midload_pending", 32'(cfg_pending[0]), 1);
        k = 0;
        while (cfg_pending[0] && k < 600) begin
            step();
            k++;
        end
        chk("midload_latency", k, 399);
        measure(0, 20, h, t);
        chk("div5_high", h, 8);
        chk("div5_ticks", t, 4);
        drain(0);

        // Duty/divide table on channel 1, loaded while idle.
        foreach (vecs[i]) begin
            load(1, vecs[i].div_in, vecs[i].high_in);
            chk("idle_pending_set", 32'(cfg_pending[1]), 1);
            step();
            chk("idle_pending_clr", 32'(cfg_pending[1]), 0);
            en[1] = 1'b1;
            measure(1, 4 * vecs[i].eff_div, h, t);
            chk("vec_high", h, vecs[i].exp_high);
            chk("vec_ticks", t, vecs[i].exp_ticks);
            drain(1);
        end

        // Dropping en mid-period finishes the period.
        load(2, 20, 10);
        step();
        en[2] = 1'b1;
        wait_pos(2, 10);
        en[2] = 1'b0;
        k = 0;
        while (busy[2] && k < 40) begin
            step();
            k++;
        end
        chk("drop_en_cycles", k, 10);

        // Re-asserting before the wrap keeps the waveform seamless.
        en[2] = 1'b1;
        wait_pos(2, 10);
        en[2] = 1'b0;
        wait_pos(2, 15);
        en[2] = 1'b1;
        measure(2, 40, h, t);
        chk("reassert_high", h, 20);
        chk("reassert_ticks", t, 2);
        chk("reassert_busy", 32'(busy[2]), 1);

        // Load sampled on the wrap edge is active at once.
        wait_pos(2, 19);
        load(2, 6, 3);
        chk("wrapload_pending", 32'(cfg_pending[2]), 0);
        measure(2, 12, h, t);
        chk("wrapload_high", h, 6);
        chk("wrapload_ticks", t, 2);

        // Double load: only the last value takes effect.
        wait_pos(2, 1);
        load(2, 8, 1);
        load(2, 10, 4);
        k = 0;
        while (cfg_pending[2] && k < 20) begin
            step();
            k++;
        end
        if (k >= 20) timeout("double_load_apply");
        measure(2, 30, h, t);
        chk("double_high", h, 12);
        chk("double_ticks", t, 3);

        // Unmapped channel select changes nothing.
        load(3, 9, 9);
        chk("badsel_pending", 32'(cfg_pending), 0);
        measure(2, 30, h, t);
        chk("badsel_high", h, 12);
        chk("badsel_ticks", t, 3);

        // Asynchronous reset with a load pending.
        en[0] = 1'b1;
        step();
        load(0, 9, 4);
        chk("prereset_pending", 32'(cfg_pending[0]), 1);
        #3 reset = 1'b1;
        #1;
        chk("async_clk_out", 32'(clk_out), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_pending", 32'(cfg_pending), 0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        chk("hold_busy", 32'(busy), 0);
        reset = 1'b0;
        en[2] = 1'b0;
        measure(0, 500, h, t);
        chk("postreset_high", h, 250);
        chk("postreset_ticks", t, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            cfg_load = ($urandom_range(0, 5) == 0);
            cfg_sel  = SW'($urandom_range(0, 3));
            cfg_div  = DW'($urandom_range(0, 12));
            cfg_high = DW'($urandom_range(0, 14));
            step();
        end
        cfg_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
